// File: rtl/lane_sum_pkg.sv
// Shared constants and helpers for the lane adder tree.
// Latency: none (package only).
// Backpressure: not applicable.
package lane_sum_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LANES = 2;
    localparam int DEF_ACC_W = 16;

    // Width of the partial sums held at tree level k.
    function automatic int lvl_w(input int width, input int k);
        return width + k + 1;
    endfunction

    // Clamp v to the largest value representable in w bits.
    function automatic logic [31:0] sat_to(input logic [31:0] v, input int w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/lane_sum_level.sv
// One registered adder-tree level: sums adjacent pairs of IN_W-bit fields.
// Latency: 1 cycle.
// Backpressure: every register holds while adv is low.
module lane_sum_level #(
    parameter int IN_W  = 4,
    parameter int PAIRS = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        adv,
    input  logic [2*PAIRS*IN_W-1:0]     in_data,
    input  logic                        in_valid,
    input  logic                        in_clr,
    output logic [PAIRS*(IN_W+1)-1:0]   sum_nxt,
    output logic [PAIRS*(IN_W+1)-1:0]   out_data,
    output logic                        out_valid,
    output logic                        out_clr
);

    localparam int OW = IN_W + 1;

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        assign sum_nxt[p*OW +: OW] = OW'(in_data[2*p*IN_W +: IN_W])
                                   + OW'(in_data[(2*p+1)*IN_W +: IN_W]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_clr   <= 1'b0;
        end else if (adv) begin
            out_data  <= sum_nxt;
            out_valid <= in_valid;
            out_clr   <= in_clr;
        end
    end

endmodule

// File: rtl/lane_sum_pipe.sv
// Pipelined lane adder with running total; LANE_SUM_SATURATE_EN clamps out_sum.
// Latency: $clog2(LANES) register stages from accept to out_valid.
// Backpressure: global stall, in_ready = !out_valid || out_ready.
module lane_sum_pipe
    import lane_sum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [LANES*WIDTH-1:0]            in_data,
    input  logic                              in_clr,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [WIDTH+$clog2(LANES)-1:0]    out_sum_full,
    output logic [WIDTH-1:0]                  out_sum,
    output logic [ACC_W-1:0]                  out_total,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int LEVELS = $clog2(LANES);
    localparam int SW     = WIDTH + LEVELS;

    logic             adv;
    logic [ACC_W-1:0] total;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IW = lvl_w(WIDTH, k) - 1;
        localparam int P  = LANES >> (k + 1);

        logic [2*P*IW-1:0]  d_in;
        logic               v_in;
        logic               c_in;
        logic [P*(IW+1)-1:0] d_nxt;
        logic [P*(IW+1)-1:0] d_q;
        logic               v_q;
        logic               c_q;

        if (k == 0) begin : g_src
            assign d_in = in_data;
            assign v_in = in_valid;
            assign c_in = in_clr;
        end else begin : g_src
            assign d_in = g_lvl[k-1].d_q;
            assign v_in = g_lvl[k-1].v_q;
            assign c_in = g_lvl[k-1].c_q;
        end

        lane_sum_level #(
            .IN_W  (IW),
            .PAIRS (P)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .in_data   (d_in),
            .in_valid  (v_in),
            .in_clr    (c_in),
            .sum_nxt   (d_nxt),
            .out_data  (d_q),
            .out_valid (v_q),
            .out_clr   (c_q)
        );
    end

    // The total is computed from the sum entering the output stage so it
    // appears on the same cycle as that beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
        end else if (adv && g_lvl[LEVELS-1].v_in) begin
            if (g_lvl[LEVELS-1].c_in) begin
                total <= ACC_W'(g_lvl[LEVELS-1].d_nxt);
            end else begin
                total <= total + ACC_W'(g_lvl[LEVELS-1].d_nxt);
            end
        end
    end

    assign out_sum_full = g_lvl[LEVELS-1].d_q[SW-1:0];
    assign out_valid    = g_lvl[LEVELS-1].v_q;
    assign out_total    = total;

    // The output stage's clr bit has already been consumed by the total.
    logic unused_clr;
    assign unused_clr = g_lvl[LEVELS-1].c_q;

`ifdef LANE_SUM_SATURATE_EN
    logic [31:0] sat_sum;
    assign sat_sum = sat_to(32'(out_sum_full), WIDTH);
    assign out_sum = sat_sum[WIDTH-1:0];
`else
    assign out_sum = out_sum_full[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_lane_sum_pipe.sv
// Directed bench for lane_sum_pipe across three parameter sets.
// Latency: n/a.
// Backpressure: n/a.
module tb_lane_sum_pipe;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LANES=2, WIDTH=4, ACC_W=16
    logic [7:0]  a_data;
    logic        a_clr, a_iv, a_ir, a_ov, a_or;
    logic [4:0]  a_sf;
    logic [3:0]  a_s;
    logic [15:0] a_t;

    // LANES=4, WIDTH=4, ACC_W=16
    logic [15:0] b_data;
    logic        b_clr, b_iv, b_ir, b_ov, b_or;
    logic [5:0]  b_sf;
    logic [3:0]  b_s;
    logic [15:0] b_t;

    // LANES=2, WIDTH=4, ACC_W=8
    logic [7:0]  c_data;
    logic        c_clr, c_iv, c_ir, c_ov, c_or;
    logic [4:0]  c_sf;
    logic [3:0]  c_s;
    logic [7:0]  c_t;

    lane_sum_pipe #(.WIDTH(4), .LANES(2), .ACC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_clr(a_clr),
        .in_valid(a_iv), .in_ready(a_ir), .out_sum_full(a_sf), .out_sum(a_s),
        .out_total(a_t), .out_valid(a_ov), .out_ready(a_or)
    );

    lane_sum_pipe #(.WIDTH(4), .LANES(4), .ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_clr(b_clr),
        .in_valid(b_iv), .in_ready(b_ir), .out_sum_full(b_sf), .out_sum(b_s),
        .out_total(b_t), .out_valid(b_ov), .out_ready(b_or)
    );

    lane_sum_pipe #(.WIDTH(4), .LANES(2), .ACC_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_clr(c_clr),
        .in_valid(c_iv), .in_ready(c_ir), .out_sum_full(c_sf), .out_sum(c_s),
        .out_total(c_t), .out_valid(c_ov), .out_ready(c_or)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        a_data = '0; a_clr = 1'b0; a_iv = 1'b0; a_or = 1'b1;
        b_data = '0; b_clr = 1'b0; b_iv = 1'b0; b_or = 1'b1;
        c_data = '0; c_clr = 1'b0; c_iv = 1'b0; c_or = 1'b1;

        #12;
        chk("rst_ov", a_ov, 0);
        chk("rst_sf", a_sf, 0);
        chk("rst_s", a_s, 0);
        chk("rst_t", a_t, 0);
        chk("rst_ir", a_ir, 1);
        chk("rst_b_ov", b_ov, 0);
        rst_n = 1'b1;
        tick();

        // Two-lane basic sum with clear
        a_data = 8'h35; a_clr = 1'b1; a_iv = 1'b1;
        tick();
        a_iv = 1'b0; a_clr = 1'b0;
        chk("l2_ov", a_ov, 1);
        chk("l2_sf", a_sf, 5'h08);
        chk("l2_s", a_s, 4'h8);
        chk("l2_t", a_t, 16'h0008);

        // Narrowing: 0xF + 0x9 = 0x18
        a_data = 8'hF9; a_iv = 1'b1;
        tick();
        a_iv = 1'b0;
        chk("nar_sf", a_sf, 5'h18);
`ifdef LANE_SUM_SATURATE_EN
        chk("nar_s", a_s, 4'hF);
`else
        chk("nar_s", a_s, 4'h8);
`endif
        chk("nar_t", a_t, 16'h0020);
        tick();
        chk("l2_bubble", a_ov, 0);

        // Four lanes back-to-back
        b_data = 16'hFFFF; b_clr = 1'b1; b_iv = 1'b1;
        tick();
        chk("l4_lat", b_ov, 0);
        b_data = 16'h1111; b_clr = 1'b0;
        tick();
        chk("l4_ov0", b_ov, 1);
        chk("l4_sf0", b_sf, 6'h3C);
        chk("l4_t0", b_t, 16'h003C);
        b_data = 16'h0000;
        tick();
        b_iv = 1'b0;
        chk("l4_ov1", b_ov, 1);
        chk("l4_sf1", b_sf, 6'h04);
        chk("l4_t1", b_t, 16'h0040);
        tick();
        chk("l4_ov2", b_ov, 1);
        chk("l4_sf2", b_sf, 6'h00);
        chk("l4_t2", b_t, 16'h0040);
        tick();
        chk("l4_idle", b_ov, 0);

        // Backpressure: X=0x1234 (sum 0x0A), Y=0x2222 (8), Z=0x0F0F (0x1E)
        b_or = 1'b0;
        b_data = 16'h1234; b_clr = 1'b1; b_iv = 1'b1;
        tick();
        chk("bp_ir_pre", b_ir, 1);
        b_data = 16'h2222; b_clr = 1'b0;
        tick();
        chk("bp_ov", b_ov, 1);
        chk("bp_ir", b_ir, 0);
        b_data = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_ov", b_ov, 1);
            chk("bp_hold_sf", b_sf, 6'h0A);
            chk("bp_hold_t", b_t, 16'h000A);
            chk("bp_hold_ir", b_ir, 0);
        end
        b_or = 1'b1;
        tick();
        b_iv = 1'b0;
        chk("bp_y_sf", b_sf, 6'h08);
        chk("bp_y_t", b_t, 16'h0012);
        tick();
        chk("bp_z_ov", b_ov, 1);
        chk("bp_z_sf", b_sf, 6'h1E);
        chk("bp_z_t", b_t, 16'h0030);
        tick();
        chk("bp_end", b_ov, 0);

        // Total wrap at ACC_W=8: 30 per beat
        for (int i = 1; i <= 9; i++) begin
            c_data = 8'hFF; c_clr = (i == 1); c_iv = 1'b1;
            tick();
            chk("wrap_ov", c_ov, 1);
            chk("wrap_sf", c_sf, 5'h1E);
            chk("wrap_t", c_t, (30 * i) % 256);
        end
        c_iv = 1'b0; c_clr = 1'b0;
        chk("wrap_last", c_t, 8'h0E);

        // Reset with beats in flight
        b_data = 16'h1111; b_clr = 1'b1; b_iv = 1'b1;
        tick();
        b_data = 16'h2222; b_clr = 1'b0;
        tick();
        b_iv = 1'b0; b_data = '0;
        chk("fl_pre_ov", b_ov, 1);
        rst_n = 1'b0;
        #1;
        chk("fl_ov", b_ov, 0);
        chk("fl_sf", b_sf, 0);
        chk("fl_t", b_t, 0);
        chk("fl_ir", b_ir, 1);
        #1;
        rst_n = 1'b1;
        tick();
        chk("fl_gone0", b_ov, 0);
        tick();
        chk("fl_gone1", b_ov, 0);
        b_data = 16'h0123; b_clr = 1'b0; b_iv = 1'b1;
        tick();
        b_iv = 1'b0;
        tick();
        chk("fl_new_ov", b_ov, 1);
        chk("fl_new_sf", b_sf, 6'h06);
        chk("fl_new_t", b_t, 16'h0006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_sum_pipe.md
# lane_sum_pipe

Pipelined, parametrised lane adder. It splits a packed input word into `LANES` unsigned fields of `WIDTH` bits and sums them through a registered adder tree. Results leave over a valid/ready handshake, and a running total accumulates across beats. It generalises the existing two-nibble combinational adder to arbitrary lane count and width, adds backpressure, and sits between a packed-data producer and any consumer of lane sums.

## Interface
Parameters:
- `WIDTH`, 4: bits per lane, ≥1.
- `LANES`, 2: lane count; power of two, ≥2.
- `ACC_W`, 16: running-total width, ≥ `WIDTH+$clog2(LANES)`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, `LANES*WIDTH`: lane i = bits `[i*WIDTH +: WIDTH]`; lane 0 = LSBs.
- `in_clr`, in, 1: this beat restarts the running total.
- `in_valid`, in, 1: beat offered.
- `in_ready`, out, 1: beat accepted when `in_valid && in_ready` at a rising edge.
- `out_sum_full`, out, `WIDTH+$clog2(LANES)`: exact sum.
- `out_sum`, out, `WIDTH`: narrowed sum (see Configuration).
- `out_total`, out, `ACC_W`: running total after this beat.
- `out_valid`, out, 1: result offered.
- `out_ready`, in, 1: result consumed when `out_valid && out_ready`.

## Operation
- `LEVELS = $clog2(LANES)`. Tree level k holds `LANES>>(k+1)` registered partial sums of width `WIDTH+k+1`, plus a valid bit and the beat's `in_clr`.
- All arithmetic is unsigned and zero-extended. No partial sum can overflow at its level.
- Global stall: `adv = !out_valid || out_ready`, and `in_ready = adv` (combinational). When `adv` is high every level shifts forward one stage. Bubbles propagate as valid=0. When `adv` is low, every register holds.
- The output stage is the last tree level. `out_sum_full` is the exact lane sum.
- Running total: a register `total` is updated in the same edge that a beat enters the output stage. If the beat's clr bit is set, `total <= sum_full`. Otherwise `total <= total + sum_full`, modulo 2^ACC_W. `out_total` shows the updated value together with that beat.
- `out_sum_full`, `out_sum` and `out_total` are stable while `out_valid && !out_ready`.
- Reset (asynchronous, any time, including mid-pipeline): all valid bits 0, all data registers 0, `total` 0. In-flight beats are discarded. After reset: `out_valid=0`, `out_sum_full=0`, `out_sum=0`, `out_total=0`, and `in_ready=1`. The first accepted beat accumulates onto 0.

## Timing
- Latency: a beat accepted at edge t gives `out_valid=1` after edge t+LEVELS-1 when there is no stall. For `LANES=2` it is visible the cycle after acceptance.
- Throughput: one beat per cycle while `out_ready` stays high.
- Simultaneous output handshake and input accept are allowed in the same cycle, and the pipeline advances.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational path exists.
- `in_valid` is not required to be held, because `in_ready` is known in the same cycle. `out_valid` holds until consumed.

## Configuration
- `LANE_SUM_SATURATE_EN` defined: `out_sum = (out_sum_full > 2^WIDTH-1) ? 2^WIDTH-1 : out_sum_full[WIDTH-1:0]`.
- Not defined: `out_sum = out_sum_full[WIDTH-1:0]`, which wraps modulo 2^WIDTH. This is the legacy adder behaviour.
- The macro affects only `out_sum`. `out_total` always wraps modulo 2^ACC_W.

## Structure
- Package `lane_sum_pkg`: a function computing level width `WIDTH+k+1`, a saturation helper function, and the default parameter constants.
- Sub-module `lane_sum_level`: one registered tree level. It is parametrised by input width and pair count, sums adjacent pairs, registers on `adv`, and carries the valid/clr bits. The top module instantiates `LEVELS` of them via generate, then adds the accumulator and narrowing logic.

## Test plan
- `LANES=2`, `WIDTH=4`, `in_data=8'h35`, `in_clr=1`: after 1 cycle `out_sum_full=5'h08`, `out_sum=4'h8`, `out_total=16'h0008`.
- `LANES=2`, `in_data=8'hF9`: `out_sum_full=5'h18`. `out_sum=4'h8` without the macro, `4'hF` with `LANE_SUM_SATURATE_EN`.
- `LANES=4`, `WIDTH=4`: stream `16'hFFFF`, `16'h1111`, `16'h0000` back-to-back with `in_clr` only on the first. Outputs appear on three consecutive cycles 2 cycles after issue: sums 0x3C, 0x04, 0x00; totals 0x3C, 0x40, 0x40.
- Backpressure: hold `out_ready=0` for 5 cycles with 3 beats in flight. `in_ready=0` while `out_valid=1`, outputs stay stable, no beat is lost or duplicated, and order is preserved on release.
- Total wrap, `ACC_W=8`: 9 beats of `LANES=2` `8'hFF` (sum 30 each). `out_total` reads 30, 60, …, 240, 14 (270 mod 256).
- Assert `rst_n=0` mid-stream with 2 beats in flight. Outputs are 0 immediately, with no `out_valid` for the flushed beats. The next beat after release gives `out_total` equal to its own sum.
